// File: rtl/bot_updt_source.sv
// Rojobot stand-in: moves a bot pose on a fixed update period and publishes it
// through a level update flag that software clears with INT_ACK.
module bot_updt_source #(
  parameter logic [23:0] UPDT_PERIOD = 24'd750000,
  parameter logic [7:0]  WORLD_MAX   = 8'd127,
  parameter logic [7:0]  INIT_X      = 8'd64,
  parameter logic [7:0]  INIT_Y      = 8'd64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] i_motctl,
  input  logic       i_int_ack,
  output logic       o_botupdt,
  output logic [7:0] o_locx,
  output logic [7:0] o_locy,
  output logic [7:0] o_sensors,
  output logic [7:0] o_botinfo,
  output logic [7:0] o_missed,
  output logic [1:0] o_state
);

  // Handshake: o_botupdt rises together with the new pose and stays high,
  // with every published register frozen, until i_int_ack is sampled high in
  // NOTIFY; i_int_ack is ignored in every other state.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_NOTIFY = 2'd2
  } state_t;

  localparam logic [2:0] MOT_STOP  = 3'd0;
  localparam logic [2:0] MOT_FWD   = 3'd1;
  localparam logic [2:0] MOT_REV   = 3'd2;
  localparam logic [2:0] MOT_RIGHT = 3'd3;
  localparam logic [2:0] MOT_LEFT  = 3'd4;

  state_t      state;
  logic [23:0] cnt;
  logic        tick;
  logic [2:0]  heading;
  logic [2:0]  motion;
  logic        bump;

  function automatic logic [7:0] sens_of(input logic [7:0] x, input logic [7:0] y);
    sens_of = {4'b0000, (x == 8'd0), (y == WORLD_MAX), (x == WORLD_MAX), (y == 8'd0)};
  endfunction

  // Period counter never stalls, so tick spacing is independent of acks.
  assign tick = (cnt == UPDT_PERIOD - 24'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  logic [3:0] nib_l;
  logic [3:0] nib_r;
  logic       l_fwd;
  logic       l_rev;
  logic       r_fwd;
  logic       r_rev;

  assign nib_l = i_motctl[7:4];
  assign nib_r = i_motctl[3:0];
  assign l_fwd = (nib_l != 4'd0) && !nib_l[3];
  assign l_rev = nib_l[3];
  assign r_fwd = (nib_r != 4'd0) && !nib_r[3];
  assign r_rev = nib_r[3];

  logic [2:0] motion_next;
  logic [2:0] heading_next;

  always_comb begin
    motion_next  = MOT_STOP;
    heading_next = heading;
    if (l_fwd && r_fwd) begin
      motion_next = MOT_FWD;
    end else if (l_rev && r_rev) begin
      motion_next = MOT_REV;
    end else if (l_fwd) begin
      motion_next  = MOT_RIGHT;
      heading_next = heading + 3'd1;
    end else if (r_fwd) begin
      motion_next  = MOT_LEFT;
      heading_next = heading - 3'd1;
    end
  end

  logic signed [9:0] dx;
  logic signed [9:0] dy;
  logic signed [9:0] cand_x;
  logic signed [9:0] cand_y;
  logic              off_map;
  logic [7:0]        new_x;
  logic [7:0]        new_y;

  // Candidate position is computed wide and signed so edge crossings are visible.
  always_comb begin
    dx = '0;
    dy = '0;
    case (heading)
      3'd1, 3'd2, 3'd3: dx = 10'sd1;
      3'd5, 3'd6, 3'd7: dx = -10'sd1;
      default:          dx = '0;
    endcase
    case (heading)
      3'd7, 3'd0, 3'd1: dy = -10'sd1;
      3'd3, 3'd4, 3'd5: dy = 10'sd1;
      default:          dy = '0;
    endcase
    cand_x = $signed({2'b00, o_locx});
    cand_y = $signed({2'b00, o_locy});
    if (motion_next == MOT_FWD) begin
      cand_x = cand_x + dx;
      cand_y = cand_y + dy;
    end else if (motion_next == MOT_REV) begin
      cand_x = cand_x - dx;
      cand_y = cand_y - dy;
    end
    off_map = cand_x[9] || cand_y[9] ||
              (cand_x[8:0] > {1'b0, WORLD_MAX}) ||
              (cand_y[8:0] > {1'b0, WORLD_MAX});
    new_x = off_map ? o_locx : cand_x[7:0];
    new_y = off_map ? o_locy : cand_y[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      o_botupdt <= 1'b0;
      o_missed  <= '0;
      o_locx    <= INIT_X;
      o_locy    <= INIT_Y;
      o_sensors <= sens_of(INIT_X, INIT_Y);
      heading   <= '0;
      motion    <= MOT_STOP;
      bump      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          o_locx    <= new_x;
          o_locy    <= new_y;
          o_sensors <= sens_of(new_x, new_y);
          heading   <= heading_next;
          motion    <= motion_next;
          bump      <= off_map;
          o_botupdt <= 1'b1;
          state     <= ST_NOTIFY;
        end
        ST_NOTIFY: begin
          if (i_int_ack) begin
            // A tick coinciding with the ack is lost, so it is counted.
            o_botupdt <= 1'b0;
            o_missed  <= tick ? 8'd1 : 8'd0;
            state     <= ST_IDLE;
          end else if (tick && (o_missed != 8'hFF)) begin
            o_missed <= o_missed + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_botinfo = {bump, 1'b0, motion, heading};
  assign o_state   = state;

endmodule

// File: tb/tb_bot_updt_source.sv
// Bench for bot_updt_source with an 8-cycle update period: table vectors,
// wall/missed/reset sequences and random commands against a pose model.
module tb_bot_updt_source;

  localparam logic [23:0] PERIOD = 24'd8;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] i_motctl = 8'h00;
  logic       i_int_ack = 1'b0;
  logic       o_botupdt;
  logic [7:0] o_locx;
  logic [7:0] o_locy;
  logic [7:0] o_sensors;
  logic [7:0] o_botinfo;
  logic [7:0] o_missed;
  logic [1:0] o_state;

  bot_updt_source #(.UPDT_PERIOD(PERIOD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_motctl  (i_motctl),
    .i_int_ack (i_int_ack),
    .o_botupdt (o_botupdt),
    .o_locx    (o_locx),
    .o_locy    (o_locy),
    .o_sensors (o_sensors),
    .o_botinfo (o_botinfo),
    .o_missed  (o_missed),
    .o_state   (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Edge index since reset release: ticks are sampled on edges that are multiples of P.
  int edge_n;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // ---------------- reference model ----------------
  int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int mx, my, mh, mmot, mbump, mbase;
  int flag_edge;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pub;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] mot;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] info;
    logic [7:0] sens;
  } vec_t;
  vec_t vt[11];

  task automatic model_reset();
    mx = 64; my = 64; mh = 0; mmot = 0; mbump = 0; mbase = 0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [7:0] m);
    int l, r, nx, ny, s;
    bit lf, lr, rf, rr;
    logic [7:0] info, sens, xb, yb;
    l = int'(m[7:4]); r = int'(m[3:0]);
    lf = (l >= 1 && l <= 7); lr = (l >= 8);
    rf = (r >= 1 && r <= 7); rr = (r >= 8);
    if (lf && rf)      mmot = 1;
    else if (lr && rr) mmot = 2;
    else if (lf)       mmot = 3;
    else if (rf)       mmot = 4;
    else               mmot = 0;
    mbump = 0;
    if (mmot == 3) mh = (mh + 1) % 8;
    if (mmot == 4) mh = (mh + 7) % 8;
    if (mmot == 1 || mmot == 2) begin
      s = (mmot == 1) ? 1 : -1;
      nx = mx + s * DX[mh];
      ny = my + s * DY[mh];
      if (nx < 0 || nx > 127 || ny < 0 || ny > 127) mbump = 1;
      else begin mx = nx; my = ny; end
    end
    xb = mx[7:0]; yb = my[7:0];
    info = {mbump[0], 1'b0, mmot[2:0], mh[2:0]};
    sens = {4'b0000, (mx == 0), (my == 127), (mx == 127), (my == 0)};
    exp_q.push_back({xb, yb, info, sens});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] pub();
    return {o_locx, o_locy, o_botinfo, o_sensors};
  endfunction

  function automatic int exp_missed();
    int v;
    v = mbase + (edge_n / P) - (flag_edge / P);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_pub"}, pub(), {8'd64, 8'd64, 8'h00, 8'h00});
    check({tag, "_flag"}, {31'd0, o_botupdt}, 32'd0);
    check({tag, "_missed"}, {24'd0, o_missed}, 32'd0);
    check({tag, "_state"}, {30'd0, o_state}, 32'd0);
  endtask

  // Called in IDLE just after an ack (or reset release): next flag = next tick edge + 1.
  task automatic wait_update(input logic [7:0] m);
    int target, guard;
    target = (edge_n / P + 1) * P + 1;
    i_motctl = m;
    model_apply(m);
    guard = 0;
    while (!o_botupdt && guard < 40) begin
      step();
      guard++;
    end
    check("flag_edge", edge_n, target);
    check("flag_high", {31'd0, o_botupdt}, 32'd1);
    flag_edge = edge_n;
    exp_pub = exp_q.pop_front();
    check("pose", pub(), exp_pub);
  endtask

  task automatic hold_and_ack(input int ack_edge);
    while (edge_n < ack_edge - 1) begin
      step();
      check("frozen", pub(), exp_pub);
      check("pending", {31'd0, o_botupdt}, 32'd1);
      check("missed", {24'd0, o_missed}, exp_missed());
    end
    i_int_ack = 1'b1;
    step();
    i_int_ack = 1'b0;
    mbase = (edge_n % P == 0) ? 1 : 0;
    check("ack_flag", {31'd0, o_botupdt}, 32'd0);
    check("ack_missed", {24'd0, o_missed}, mbase);
    check("ack_pose", pub(), exp_pub);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vt[0]  = '{8'h11, 8'd64, 8'd63, 8'h08, 8'h00};
    vt[1]  = '{8'h99, 8'd64, 8'd64, 8'h10, 8'h00};
    for (int i = 2; i < 10; i++) begin
      vt[i].mot  = 8'h19;
      vt[i].x    = 8'd64;
      vt[i].y    = 8'd64;
      vt[i].info = 8'h18 | 8'((i - 1) % 8);
      vt[i].sens = 8'h00;
    end
    vt[10] = '{8'h91, 8'd64, 8'd64, 8'h27, 8'h00};

    model_reset();
    rstn = 1'b0;
    repeat (3) step();
    check_reset("reset_hold");
    rstn = 1'b1;
    check_reset("reset_release");

    // Forward/reverse and turn table
    for (int i = 0; i < 11; i++) begin
      wait_update(vt[i].mot);
      check($sformatf("table_%0d", i), pub(), {vt[i].x, vt[i].y, vt[i].info, vt[i].sens});
      hold_and_ack(flag_edge + 1 + $urandom_range(0, 10));
    end

    // Wall bump: face north, drive to y=0, then one more step
    wait_update(8'h19);
    hold_and_ack(flag_edge + 2);
    for (int i = 0; i < 64; i++) begin
      wait_update(8'h11);
      if (i == 63) begin
        check("wall_y", {24'd0, o_locy}, 32'd0);
        check("wall_sens", {24'd0, o_sensors}, 32'h01);
      end
      hold_and_ack(flag_edge + 1 + $urandom_range(0, 5));
    end
    wait_update(8'h11);
    check("bump_bit", {31'd0, o_botinfo[7]}, 32'd1);
    check("bump_y", {24'd0, o_locy}, 32'd0);
    hold_and_ack(flag_edge + 2);

    // Missed ticks: three withheld, then ack off-tick, then ack on a tick
    wait_update(8'h00);
    while (edge_n < flag_edge + 23) begin
      step();
      check("missed_frozen", pub(), exp_pub);
    end
    check("missed_3", {24'd0, o_missed}, 32'd3);
    hold_and_ack(flag_edge + 24);
    check("missed_clear", {24'd0, o_missed}, 32'd0);
    wait_update(8'h00);
    hold_and_ack(flag_edge + 7);
    check("missed_coincident", {24'd0, o_missed}, 32'd1);

    // Saturation of the missed counter
    wait_update(8'h00);
    hold_and_ack(flag_edge + P * 258 + 2);

    // Random commands with random ack delays
    for (int i = 0; i < 40; i++) begin
      wait_update(8'($urandom_range(0, 255)));
      hold_and_ack(flag_edge + 1 + $urandom_range(0, 20));
    end

    // Asynchronous reset in NOTIFY with missed=2
    wait_update(8'h00);
    hold_and_ack(flag_edge + 2);
    wait_update(8'h11);
    while (edge_n < flag_edge + 16) step();
    check("pre_reset_missed", {24'd0, o_missed}, 32'd2);
    check("pre_reset_flag", {31'd0, o_botupdt}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset("reset_async");
    step();
    rstn = 1'b1;
    model_reset();
    check_reset("reset_after");
    wait_update(8'h11);
    hold_and_ack(flag_edge + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always reaches its summary.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
